// File: rtl/pio_out_pkg.sv
// pio_out_pkg: register map offsets and timer width for the blinking PIO
package pio_out_pkg;
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_SET      = 3'd2;
    localparam logic [2:0] ADDR_CLEAR    = 3'd3;
    localparam logic [2:0] ADDR_TOGGLE   = 3'd4;
    localparam logic [2:0] ADDR_PERIOD   = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;
    localparam int PERIOD_W = 16;
endpackage

// File: rtl/blink_timer.sv
// blink_timer: prescaler plus period counter producing the blink phase
module blink_timer
    import pio_out_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [PW-1:0]       pre;
    logic [PERIOD_W-1:0] cnt;
    logic                tick, wrap;
    assign tick = pre == PW'(PRESCALE - 1);
    assign wrap = tick && cnt == period - 1'b1;
    // A zero period parks everything with phase high, i.e. blink disabled
    always_ff @(posedge clk) begin
        if (reset || restart || period == '0) begin
            pre   <= '0;
            cnt   <= '0;
            phase <= 1'b1;
        end else begin
            pre   <= tick ? '0 : pre + 1'b1;
            cnt   <= wrap ? '0 : cnt + PERIOD_W'(tick);
            phase <= phase ^ wrap;
        end
    end
endmodule

// File: rtl/pio_out_blink.sv
// pio_out_blink: Avalon-MM output PIO with set/clear/toggle and masked blinking
module pio_out_blink
    import pio_out_pkg::*;
#(
    parameter int          WIDTH       = 7,
    parameter logic [31:0] RESET_VALUE = 0,
    parameter int          PRESCALE    = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    logic [WIDTH-1:0]    data, blink_en, wd;
    logic [PERIOD_W-1:0] period;
    logic                wr, phase, unused_bits;
    assign wr          = chipselect & ~write_n;
    assign wd          = writedata[WIDTH-1:0];
    assign unused_bits = &{1'b0, writedata};
    blink_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .period  (period),
        .restart (wr && address == ADDR_PERIOD),
        .phase   (phase)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            data     <= RESET_VALUE[WIDTH-1:0];
            blink_en <= '0;
            period   <= '0;
            out_port <= RESET_VALUE[WIDTH-1:0];
        end else begin
            out_port <= data & ~(blink_en & {WIDTH{~phase}});
            if (wr) begin
                case (address)
                    ADDR_DATA:     data     <= wd;
                    ADDR_BLINK_EN: blink_en <= wd;
                    ADDR_SET:      data     <= data | wd;
                    ADDR_CLEAR:    data     <= data & ~wd;
                    ADDR_TOGGLE:   data     <= data ^ wd;
                    ADDR_PERIOD:   period   <= writedata[PERIOD_W-1:0];
                    default:       ;
                endcase
            end
        end
    end
    always_comb begin
        readdata = address == ADDR_DATA     ? 32'(data)     :
                   address == ADDR_BLINK_EN ? 32'(blink_en) :
                   address == ADDR_PERIOD   ? 32'(period)   :
                   address == ADDR_STATUS   ? {31'd0, phase} : 32'd0;
    end
endmodule

// File: tb/tb_pio_out_blink.sv
// tb_pio_out_blink: randomized bench against a divide-based blink model
module tb_pio_out_blink;
    localparam int          PS = 4;
    localparam logic [31:0] RV = 32'h12;
    logic        clk = 1'b0;
    logic        reset, chipselect, write_n;
    logic [2:0]  address;
    logic [31:0] writedata, rd7, rd32, out32;
    logic [6:0]  out7;
    int          errors = 0, checks = 0;
    logic [31:0] m_data = 0, m_en = 0, m_out = 0;
    logic [15:0] m_per = 0;
    int          m_n = 0;

    always #5 clk = ~clk;

    pio_out_blink #(.WIDTH(7), .RESET_VALUE(RV), .PRESCALE(PS)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd7), .out_port(out7)
    );
    pio_out_blink #(.WIDTH(32), .RESET_VALUE(RV), .PRESCALE(PS)) dut32 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd32), .out_port(out32)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // phase flips once every PS*period clocks counted from the last restart
    function automatic logic m_phase();
        if (m_per == 0) return 1'b1;
        return ((m_n / (PS * int'(m_per))) % 2) == 0;
    endfunction

    function automatic logic [31:0] m_read(logic [2:0] a, logic [31:0] mask);
        case (a)
            3'd0:    return m_data & mask;
            3'd1:    return m_en & mask;
            3'd5:    return 32'(m_per);
            3'd6:    return {31'd0, m_phase()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic cycle(logic r, logic w, logic [2:0] a, logic [31:0] d);
        logic [31:0] nout;
        reset = r; chipselect = w; write_n = ~w; address = a; writedata = d;
        @(posedge clk);
        nout = r ? RV : (m_data & ~(m_en & {32{~m_phase()}}));
        if (r) begin
            m_data = RV; m_en = 0; m_per = 0; m_n = 0;
        end else begin
            m_n++;
            if (w) begin
                case (a)
                    3'd0: m_data = d;
                    3'd1: m_en = d;
                    3'd2: m_data = m_data | d;
                    3'd3: m_data = m_data & ~d;
                    3'd4: m_data = m_data ^ d;
                    3'd5: begin m_per = d[15:0]; m_n = 0; end
                    default: ;
                endcase
            end
        end
        m_out = nout;
        @(negedge clk);
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        chk("out7", 32'(out7), m_out & 32'h7F);
        chk("out32", out32, m_out);
    endtask

    task automatic rd(logic [2:0] a);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        chk($sformatf("rd7@%0d", a), rd7, m_read(a, 32'h7F));
        chk($sformatf("rd32@%0d", a), rd32, m_read(a, 32'hFFFF_FFFF));
        chipselect = 1'b0;
    endtask

    initial begin
        logic [2:0]  ops [4];
        logic [31:0] vals[4], exps[4];
        logic [31:0] d;
        logic [2:0]  a;
        int          k;
        ops  = '{3'd0, 3'd2, 3'd3, 3'd4};
        vals = '{32'h55, 32'h02, 32'h01, 32'h7F};
        exps = '{32'h55, 32'h57, 32'h56, 32'h29};
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 0; writedata = 0;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("rst_out", 32'(out7), 32'h12);
        for (int i = 0; i < 8; i++) rd(3'(i));
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, ops[i], vals[i]);
            rd(0);
            chk("bitop", rd7, exps[i]);
            cycle(0, 0, 0, 0);
        end
        cycle(0, 1, 0, 32'h7F);
        cycle(0, 1, 1, 32'h0F);
        cycle(0, 1, 5, 32'h2);
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, 0, 0);
            rd(6);
        end
        // restart coincident with a period wrap
        for (int i = 0; i < 100 && !(m_per != 0 && m_n % (PS * int'(m_per)) == PS * int'(m_per) - 1); i++)
            cycle(0, 0, 0, 0);
        chk("wrap_wait", 32'(m_n % 8), 32'd7);
        cycle(0, 1, 5, 32'h2);
        rd(6);
        chk("restart_phase", rd7, 32'd1);
        k = 0;
        do begin
            cycle(0, 0, 0, 0);
            k++;
            address = 6; #1;
        end while (rd7[0] && k < 40);
        chk("restart_gap", 32'(k), 32'd8);
        for (int i = 0; i < 40 && m_phase(); i++) cycle(0, 0, 0, 0);
        rd(6);
        chk("phase0_dis", rd7, 32'd0);
        cycle(0, 1, 5, 32'h0);
        cycle(0, 0, 0, 0);
        chk("disable_out", 32'(out7), 32'h7F);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, 0);
            rd(6);
        end
        cycle(0, 1, 5, 32'h1);
        for (int i = 0; i < 40 && m_phase(); i++) cycle(0, 0, 0, 0);
        rd(6);
        chk("phase0_rst", rd7, 32'd0);
        cycle(1, 0, 0, 0);
        chk("rst_mid_out", 32'(out7), 32'h12);
        for (int i = 0; i < 8; i++) rd(3'(i));
        cycle(0, 1, 0, 32'hFFFF_FFFF);
        rd(0);
        chk("width32", rd32, 32'hFFFF_FFFF);
        chk("width7", rd7, 32'h7F);
        for (int i = 0; i < 400; i++) begin
            a = 3'($urandom_range(0, 7));
            d = $urandom();
            if (a == 3'd5) d = {d[31:16], 16'($urandom_range(0, 3))};
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, a, d);
            rd(3'($urandom_range(0, 7)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
